// File: rtl/i2c_master.sv
// i2c_master -- bit-level I2C/SCCB engine driven by byte commands.
//
// Handshake: req is a one-cycle request that is honoured only while the
// engine is idle; cmd and din are captured in that same cycle. done is a
// one-cycle pulse on the cycle the engine returns to idle, so a new req may
// be issued in the done cycle itself. A req seen while busy is dropped.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, cmd, din   command request; cmd bit0 START, bit1 WRITE, bit2 READ,
//                   bit3 STOP (bits may be combined); din is the write byte
//   done            one-cycle completion pulse
//   dout            last read byte, updated at the done of a READ
//   slave_ack       ACK bit sampled in the last WRITE (0 = ACK), updated at done
//   scl             push-pull SCL
//   sda_out, sda_oe SDA drive value and enable (0 = released, bus pulls high)
//   sda_in          SDA pin, double-flop synchronised before use
//
// Each bus period is SCL_PERIOD clocks: SCL low for phases 0..SCL_HALF-1 and
// high for the rest. SDA changes at LOW_HALF and is sampled (or makes the
// START/STOP edge) at HIGH_HALF. Registered outputs are loaded one phase
// early so the change is visible exactly at the named phase.
module i2c_master #(
  parameter int SCL_PERIOD = 250,
  parameter int SCL_HALF   = 125,
  parameter int LOW_HALF   = 65,
  parameter int HIGH_HALF  = 190
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] cmd,
  input  logic [7:0] din,
  output logic       done,
  output logic [7:0] dout,
  output logic       slave_ack,
  output logic       scl,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam logic [7:0] PH_LAST     = 8'(SCL_PERIOD - 1);
  localparam logic [7:0] PH_SCL_RISE = 8'(SCL_HALF - 1);
  localparam logic [7:0] PH_SDA_SET  = 8'(LOW_HALF - 1);
  localparam logic [7:0] PH_EDGE     = 8'(HIGH_HALF - 1);
  localparam logic [7:0] PH_SAMPLE   = 8'(HIGH_HALF);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WRITE, S_RACK, S_READ, S_MACK, S_STOP
  } state_t;

  state_t     state;
  logic [7:0] phase_cnt;
  logic [3:0] bit_cnt;
  logic [3:1] cmd_q;       // START is only needed to pick the first state
  logic [7:0] din_q;
  logic [7:0] rx_q;
  logic       ack_q;
  logic       sda_meta;
  logic       sda_sync;

  state_t first_state;
  state_t end_next;
  logic   period_end;
  logic   last_period;

  // First bus phase of a freshly requested command; WRITE wins over READ.
  always_comb begin
    first_state = S_IDLE;
    if (cmd[0])      first_state = S_START;
    else if (cmd[1]) first_state = S_WRITE;
    else if (cmd[2]) first_state = S_READ;
    else if (cmd[3]) first_state = S_STOP;
  end

  // Successor of the current phase once its last period finishes.
  always_comb begin
    end_next = S_IDLE;
    case (state)
      S_START: begin
        if (cmd_q[1])      end_next = S_WRITE;
        else if (cmd_q[2]) end_next = S_READ;
        else if (cmd_q[3]) end_next = S_STOP;
      end
      S_WRITE: end_next = S_RACK;
      S_RACK:  end_next = cmd_q[3] ? S_STOP : S_IDLE;
      S_READ:  end_next = S_MACK;
      S_MACK:  end_next = cmd_q[3] ? S_STOP : S_IDLE;
      default: end_next = S_IDLE;
    endcase
  end

  assign period_end  = (phase_cnt == PH_LAST);
  assign last_period = ((state == S_WRITE) || (state == S_READ)) ? (bit_cnt == 4'd7) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      cmd_q     <= '0;
      din_q     <= '0;
      rx_q      <= '0;
      ack_q     <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      done      <= 1'b0;
      dout      <= '0;
      slave_ack <= 1'b0;
      scl       <= 1'b1;
      sda_out   <= 1'b1;
      sda_oe    <= 1'b0;
    end else begin
      done     <= 1'b0;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;

      if (state == S_IDLE) begin
        phase_cnt <= '0;
        bit_cnt   <= '0;
        if (req) begin
          cmd_q <= cmd[3:1];
          din_q <= din;
          state <= first_state;
          if (first_state == S_IDLE) begin
            done <= 1'b1;          // empty command: acknowledge, no bus activity
          end else begin
            scl <= 1'b0;
          end
          if (first_state == S_START) begin
            sda_oe  <= 1'b1;
            sda_out <= 1'b1;
          end
        end
      end else begin
        phase_cnt <= period_end ? 8'd0 : phase_cnt + 8'd1;
        if (phase_cnt == PH_SCL_RISE) scl <= 1'b1;

        case (state)
          S_START: begin
            if (phase_cnt == PH_EDGE) sda_out <= 1'b0;   // START: SDA falls, SCL high
          end
          S_WRITE: begin
            if (phase_cnt == PH_SDA_SET) begin
              sda_oe  <= 1'b1;
              sda_out <= din_q[3'd7 - bit_cnt[2:0]];
            end
          end
          S_RACK: begin
            if (phase_cnt == PH_SDA_SET) begin
              sda_oe  <= 1'b0;
              sda_out <= 1'b1;
            end
            if (phase_cnt == PH_SAMPLE) ack_q <= sda_sync;
          end
          S_READ: begin
            if (phase_cnt == PH_SDA_SET) begin
              sda_oe  <= 1'b0;
              sda_out <= 1'b1;
            end
            if (phase_cnt == PH_SAMPLE) rx_q <= {rx_q[6:0], sda_sync};
          end
          S_MACK: begin
            if (phase_cnt == PH_SDA_SET) begin
              sda_oe  <= 1'b1;
              sda_out <= cmd_q[3];                     // NACK the last byte before STOP
            end
          end
          S_STOP: begin
            if (phase_cnt == PH_SDA_SET) begin
              sda_oe  <= 1'b1;
              sda_out <= 1'b0;
            end
            if (phase_cnt == PH_EDGE) sda_out <= 1'b1; // STOP: SDA rises, SCL high
          end
          default: ;
        endcase

        if (period_end) begin
          // SCL is parked low between commands; only STOP leaves it high.
          if (state != S_STOP) scl <= 1'b0;
          if (!last_period) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            bit_cnt <= '0;
            state   <= end_next;
            if (end_next == S_IDLE) begin
              done    <= 1'b1;
              sda_oe  <= 1'b0;
              sda_out <= 1'b1;
              if (cmd_q[1])      slave_ack <= ack_q;
              else if (cmd_q[2]) dout      <= rx_q;
            end
          end
        end
      end
    end
  end

endmodule
